// File: rtl/cal_block_weighted.sv
// Weighted three-ring colour accumulator for one backlight block: integrates GRB
// pixels per frame, saturates, normalises and latches one colour per frame.
module cal_block_weighted #(
  parameter int CW        = 8,
  parameter int RC_W      = 7,
  parameter int ACC_W     = 16,
  parameter int R1_T      = 53,
  parameter int R1_B      = 53,
  parameter int R1_L      = 1,
  parameter int R1_R      = 1,
  parameter int R2_T      = 52,
  parameter int R2_B      = 53,
  parameter int R2_L      = 1,
  parameter int R2_R      = 3,
  parameter int R3_T      = 51,
  parameter int R3_B      = 53,
  parameter int R3_L      = 1,
  parameter int R3_R      = 2,
  parameter int SH1       = 1,
  parameter int SH2       = 4,
  parameter int SH3       = 6,
  parameter int OUT_SHIFT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              frame_end,
  input  logic              data_rd,
  input  logic [3*CW-1:0]   GRBdata,
  input  logic [RC_W-1:0]   row_now,
  input  logic [RC_W-1:0]   col_now,
  output logic [3*CW-1:0]   result,
  output logic              result_valid,
  output logic [15:0]       pixel_cnt,
  output logic              busy
);

  typedef enum logic {S_IDLE, S_ACCUM} state_t;

  localparam int CH_MAX = (1 << CW) - 1;

  localparam logic [RC_W-1:0] R1_T_V = RC_W'(R1_T);
  localparam logic [RC_W-1:0] R1_B_V = RC_W'(R1_B);
  localparam logic [RC_W-1:0] R1_L_V = RC_W'(R1_L);
  localparam logic [RC_W-1:0] R1_R_V = RC_W'(R1_R);
  localparam logic [RC_W-1:0] R2_T_V = RC_W'(R2_T);
  localparam logic [RC_W-1:0] R2_B_V = RC_W'(R2_B);
  localparam logic [RC_W-1:0] R2_L_V = RC_W'(R2_L);
  localparam logic [RC_W-1:0] R2_R_V = RC_W'(R2_R);
  localparam logic [RC_W-1:0] R3_T_V = RC_W'(R3_T);
  localparam logic [RC_W-1:0] R3_B_V = RC_W'(R3_B);
  localparam logic [RC_W-1:0] R3_L_V = RC_W'(R3_L);
  localparam logic [RC_W-1:0] R3_R_V = RC_W'(R3_R);

  state_t            state_q;
  logic [ACC_W-1:0]  acc_q [3];
  logic [ACC_W-1:0]  acc_d [3];
  logic [15:0]       run_cnt_q;
  logic [15:0]       run_cnt_d;
  logic [3*CW-1:0]   result_q;
  logic [3*CW-1:0]   result_d;
  logic              result_valid_q;
  logic [15:0]       pixel_cnt_q;

  logic              hit1;
  logic              hit2;
  logic              hit3;
  logic              take;
  logic [CW-1:0]     ch_v;
  logic [CW-1:0]     add_v;
  logic [ACC_W:0]    sum_v;
  logic [ACC_W-1:0]  norm_v;

  function automatic logic in_rect(input logic [RC_W-1:0] r, input logic [RC_W-1:0] c,
                                   input logic [RC_W-1:0] t, input logic [RC_W-1:0] b,
                                   input logic [RC_W-1:0] l, input logic [RC_W-1:0] rr);
    return (r >= t) && (r <= b) && (c >= l) && (c <= rr);
  endfunction

  // data_rd is a valid-only strobe with no ready: every asserted cycle in ACCUM is
  // consumed on that clock edge, so the source never has to hold a pixel.
  always_comb begin
    hit1      = in_rect(row_now, col_now, R1_T_V, R1_B_V, R1_L_V, R1_R_V);
    hit2      = in_rect(row_now, col_now, R2_T_V, R2_B_V, R2_L_V, R2_R_V);
    hit3      = in_rect(row_now, col_now, R3_T_V, R3_B_V, R3_L_V, R3_R_V);
    take      = (state_q == S_ACCUM) && data_rd && (hit1 || hit2 || hit3);
    run_cnt_d = (take && (run_cnt_q != 16'hFFFF)) ? run_cnt_q + 16'd1 : run_cnt_q;
    ch_v      = '0;
    add_v     = '0;
    sum_v     = '0;
    norm_v    = '0;
    result_d  = '0;
    for (int c = 0; c < 3; c++) begin
      ch_v = GRBdata[c*CW +: CW];
      // Inner ring wins so a pixel is weighted exactly once.
      if (hit1)      add_v = ch_v >> SH1;
      else if (hit2) add_v = ch_v >> SH2;
      else           add_v = ch_v >> SH3;
      sum_v = {1'b0, acc_q[c]} + (ACC_W+1)'(add_v);
      if (!take)          acc_d[c] = acc_q[c];
      else if (sum_v[ACC_W]) acc_d[c] = '1;
      else                acc_d[c] = sum_v[ACC_W-1:0];
      norm_v = acc_d[c] >> OUT_SHIFT;
      result_d[c*CW +: CW] = (norm_v > ACC_W'(CH_MAX)) ? '1 : norm_v[CW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      run_cnt_q      <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      pixel_cnt_q    <= '0;
      for (int c = 0; c < 3; c++) acc_q[c] <= '0;
    end else begin
      result_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (frame_start) begin
            for (int c = 0; c < 3; c++) acc_q[c] <= '0;
            run_cnt_q <= '0;
            state_q   <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (frame_end) begin
            result_q       <= result_d;
            pixel_cnt_q    <= run_cnt_d;
            result_valid_q <= 1'b1;
          end
          // frame_start always wins the accumulator: restart after an optional latch.
          if (frame_start) begin
            for (int c = 0; c < 3; c++) acc_q[c] <= '0;
            run_cnt_q <= '0;
          end else begin
            for (int c = 0; c < 3; c++) acc_q[c] <= acc_d[c];
            run_cnt_q <= run_cnt_d;
            if (frame_end) state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign pixel_cnt    = pixel_cnt_q;
  assign busy         = (state_q == S_ACCUM);

endmodule

// File: tb/tb_cal_block_weighted.sv
// Directed bench for cal_block_weighted: table of single-pixel frames plus
// hand sequences for multi-pixel, saturation, restart and reset-abort cases.
module tb_cal_block_weighted;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start;
  logic        frame_end;
  logic        data_rd;
  logic [23:0] grb;
  logic [6:0]  row;
  logic [6:0]  col;

  logic [23:0] res_d, res_s0, res_s4, res_s5;
  logic        rv_d, rv_s0, rv_s4, rv_s5;
  logic [15:0] cnt_d, cnt_s0, cnt_s4, cnt_s5;
  logic        busy_d, busy_s0, busy_s4, busy_s5;

  int n_cmp = 0;
  int n_err = 0;
  logic [23:0] exp_q[$];

  typedef struct {
    logic [6:0]  r;
    logic [6:0]  c;
    logic [23:0] d;
    logic        same;
    logic [23:0] er;
    logic [15:0] ec;
  } vec_t;
  vec_t vt[9];

  cal_block_weighted u_dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .frame_end(frame_end),
    .data_rd(data_rd), .GRBdata(grb), .row_now(row), .col_now(col),
    .result(res_d), .result_valid(rv_d), .pixel_cnt(cnt_d), .busy(busy_d));

  cal_block_weighted #(.ACC_W(12), .OUT_SHIFT(0)) u_s0 (
    .clk(clk), .rst(rst), .frame_start(frame_start), .frame_end(frame_end),
    .data_rd(data_rd), .GRBdata(grb), .row_now(row), .col_now(col),
    .result(res_s0), .result_valid(rv_s0), .pixel_cnt(cnt_s0), .busy(busy_s0));

  cal_block_weighted #(.ACC_W(12), .OUT_SHIFT(4)) u_s4 (
    .clk(clk), .rst(rst), .frame_start(frame_start), .frame_end(frame_end),
    .data_rd(data_rd), .GRBdata(grb), .row_now(row), .col_now(col),
    .result(res_s4), .result_valid(rv_s4), .pixel_cnt(cnt_s4), .busy(busy_s4));

  cal_block_weighted #(.ACC_W(12), .OUT_SHIFT(5)) u_s5 (
    .clk(clk), .rst(rst), .frame_start(frame_start), .frame_end(frame_end),
    .data_rd(data_rd), .GRBdata(grb), .row_now(row), .col_now(col),
    .result(res_s5), .result_valid(rv_s5), .pixel_cnt(cnt_s5), .busy(busy_s5));

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("busy_after_start", busy_d, 1);
  endtask

  task automatic pixel(input logic [6:0] r, input logic [6:0] c, input logic [23:0] d);
    data_rd = 1'b1;
    row     = r;
    col     = c;
    grb     = d;
    tick();
    data_rd = 1'b0;
  endtask

  task automatic end_frame(input string name, input logic same, input logic [6:0] r,
                           input logic [6:0] c, input logic [23:0] d,
                           input logic [23:0] er, input logic [15:0] ec);
    check({name, "_rv_pre"}, rv_d, 0);
    frame_end = 1'b1;
    if (same) begin
      data_rd = 1'b1;
      row     = r;
      col     = c;
      grb     = d;
    end
    exp_q.push_back(er);
    tick();
    frame_end = 1'b0;
    data_rd   = 1'b0;
    check({name, "_rv"}, rv_d, 1);
    check({name, "_result"}, res_d, exp_q.pop_front());
    check({name, "_cnt"}, cnt_d, ec);
    check({name, "_busy"}, busy_d, 0);
    tick();
    check({name, "_rv_drop"}, rv_d, 0);
  endtask

  initial begin
    vt[0] = '{7'd53, 7'd1,  24'hFF8040, 1'b0, 24'h7F4020, 16'd1};
    vt[1] = '{7'd52, 7'd3,  24'hFF8040, 1'b0, 24'h0F0804, 16'd1};
    vt[2] = '{7'd10, 7'd10, 24'hFFFFFF, 1'b0, 24'h000000, 16'd0};
    vt[3] = '{7'd53, 7'd1,  24'hFFFFFF, 1'b0, 24'h7F7F7F, 16'd1};
    vt[4] = '{7'd51, 7'd2,  24'hC0C0C0, 1'b1, 24'h030303, 16'd1};
    vt[5] = '{7'd53, 7'd3,  24'h804020, 1'b0, 24'h080402, 16'd1};
    vt[6] = '{7'd51, 7'd1,  24'hFFFFFF, 1'b1, 24'h030303, 16'd1};
    vt[7] = '{7'd50, 7'd1,  24'hFFFFFF, 1'b0, 24'h000000, 16'd0};
    vt[8] = '{7'd53, 7'd2,  24'hFFFFFF, 1'b0, 24'h0F0F0F, 16'd1};

    rst = 1'b0; frame_start = 1'b0; frame_end = 1'b0; data_rd = 1'b0;
    grb = '0; row = '0; col = '0;
    tick(); tick();
    check("reset_result", res_d, 0);
    check("reset_rv", rv_d, 0);
    check("reset_cnt", cnt_d, 0);
    check("reset_busy", busy_d, 0);
    rst = 1'b1;
    tick();

    // Pixels offered while idle are dropped.
    pixel(7'd53, 7'd1, 24'hFFFFFF);
    check("idle_busy", busy_d, 0);
    start_frame();
    end_frame("idle_pixel", 1'b0, 7'd0, 7'd0, 24'h0, 24'h000000, 16'd0);

    for (int i = 0; i < 9; i++) begin
      start_frame();
      if (!vt[i].same) pixel(vt[i].r, vt[i].c, vt[i].d);
      end_frame($sformatf("vec%0d", i), vt[i].same, vt[i].r, vt[i].c, vt[i].d,
                vt[i].er, vt[i].ec);
    end

    // Ring-2 hit followed by a miss.
    start_frame();
    pixel(7'd52, 7'd3, 24'hFF8040);
    pixel(7'd10, 7'd10, 24'hFFFFFF);
    end_frame("ring2_miss", 1'b0, 7'd0, 7'd0, 24'h0, 24'h0F0804, 16'd1);

    // Saturation: 40 back-to-back ring-1 white pixels (127 each per channel).
    start_frame();
    for (int i = 0; i < 40; i++) pixel(7'd53, 7'd1, 24'hFFFFFF);
    end_frame("sat_default", 1'b0, 7'd0, 7'd0, 24'h0, 24'hFFFFFF, 16'd40);
    check("sat_os0_result", res_s0, 24'hFFFFFF);
    check("sat_os4_result", res_s4, 24'hFFFFFF);
    check("sat_os5_result", res_s5, 24'h7F7F7F);
    check("sat_os5_cnt", cnt_s5, 40);
    check("sat_os0_cnt", cnt_s0, 40);

    // Restart: latch and re-arm in one cycle.
    start_frame();
    pixel(7'd53, 7'd1, 24'h020202);
    pixel(7'd53, 7'd1, 24'h020202);
    frame_start = 1'b1;
    frame_end   = 1'b1;
    tick();
    frame_start = 1'b0;
    frame_end   = 1'b0;
    check("restart_rv", rv_d, 1);
    check("restart_result", res_d, 24'h020202);
    check("restart_cnt", cnt_d, 2);
    check("restart_busy", busy_d, 1);
    pixel(7'd53, 7'd1, 24'h101010);
    end_frame("after_restart", 1'b0, 7'd0, 7'd0, 24'h0, 24'h080808, 16'd1);

    // Reset asserted mid-frame aborts without a result pulse.
    start_frame();
    for (int i = 0; i < 3; i++) pixel(7'd53, 7'd1, 24'hFFFFFF);
    rst = 1'b0;
    #1;
    check("abort_result", res_d, 0);
    check("abort_rv", rv_d, 0);
    check("abort_cnt", cnt_d, 0);
    check("abort_busy", busy_d, 0);
    tick();
    rst = 1'b1;
    tick();
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    check("orphan_end_rv", rv_d, 0);
    check("orphan_end_busy", busy_d, 0);
    tick();
    check("orphan_end_rv2", rv_d, 0);
    check("orphan_end_result", res_d, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cal_block_weighted.md
# cal_block_weighted

Parametrised successor to the corner-block colour accumulator in the backlight path. It sits after the pixel scanner and integrates GRB pixels that fall inside one screen region with three nested weighting rings. Its one-clock, edge-synchronous datapath replaces the data_rd-clocked accumulator. It adds frame framing, saturating arithmetic, normalisation and a result-valid pulse, so the LED encoder can latch one colour per block per frame.

## Interface
Parameters:
- CW, 8, bits per colour channel; GRBdata/result are 3*CW wide, order {G,R,B}.
- RC_W, 7, width of row_now/col_now.
- ACC_W, 16, accumulator width per channel (ACC_W >= CW).
- R1_T/R1_B/R1_L/R1_R, 53/53/1/1, ring-1 rectangle (top row, bottom row, left col, right col, inclusive).
- R2_T/R2_B/R2_L/R2_R, 52/53/1/3, ring-2 rectangle.
- R3_T/R3_B/R3_L/R3_R, 51/53/1/2, ring-3 rectangle.
- SH1/SH2/SH3, 1/4/6, right-shift applied to each channel for ring 1/2/3.
- OUT_SHIFT, 0, right-shift applied to accumulator before output clamp.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse: clear accumulators, arm block.
- frame_end  in  1  one-cycle pulse: latch result from accumulators.
- data_rd  in  1  pixel-valid strobe, sampled on clk (not a clock).
- GRBdata  in  3*CW  pixel {G,R,B}.
- row_now  in  RC_W  pixel row.
- col_now  in  RC_W  pixel column.
- result  out  3*CW  latched block colour {G,R,B}.
- result_valid  out  1  one-cycle pulse when result updates.
- pixel_cnt  out  16  pixels accumulated in last latched frame, saturating at 0xFFFF.
- busy  out  1  high in ACCUM.

## Operation
- States: IDLE, ACCUM. Reset -> IDLE.
- IDLE: data_rd and frame_end ignored. frame_start -> clear acc_G/R/B and run_cnt, go ACCUM.
- ACCUM, data_rd=1: ring hit is evaluated combinationally with inclusive bounds. Priority is ring1 > ring2 > ring3, and a pixel contributes once at most. Hit in ring k adds zero-extended (ch >> SHk) to each acc_ch, saturating at 2^ACC_W-1 per channel independently, and increments run_cnt (saturating). A miss changes nothing.
- ACCUM, frame_end=1: the pixel presented the same cycle, if any, is included.
  - result_ch = min(acc_ch_next >> OUT_SHIFT, 2^CW-1).
  - pixel_cnt = run_cnt_next.
  - result_valid pulses.
  - Next state IDLE.
- ACCUM, frame_start and frame_end together: latch as above, then clear accumulators and run_cnt, stay ACCUM.
- ACCUM, frame_start alone: restart, discarding the partial frame. No result_valid.
- result and pixel_cnt hold between latches.

## Timing
- Reset values: result=0, result_valid=0, pixel_cnt=0, busy=0, accumulators 0, state IDLE. Assertion mid-frame aborts immediately. No result_valid is issued for the aborted frame.
- Accumulate latency: a pixel at edge N is reflected in the accumulator after edge N.
- Result latency: frame_end sampled at edge N -> result, pixel_cnt and result_valid=1 visible after edge N. result_valid returns low after edge N+1.
- busy rises after the edge sampling frame_start and falls after the edge sampling frame_end, unless restart applies.
- Back-to-back data_rd every cycle is supported; no stall or back-pressure.

## Test plan
- Reset: frame_start, 3 ring-1 pixels 0xFFFFFF, assert rst before frame_end -> all outputs 0, no result_valid. A later frame_end with no frame_start -> no pulse.
- Ring 1 at defaults: frame_start; pixel (53,1)=0xFF8040; frame_end -> result 0x7F4020, pixel_cnt 1, result_valid for exactly 1 cycle, 1 cycle after frame_end.
- Ring 2 only and miss: pixel (52,3)=0xFF8040, then pixel (10,10)=0xFFFFFF; frame_end -> result 0x0F0804, pixel_cnt 1. The (53,1) pixel counts once as ring 1 (0x7F), not 0x7F+0x0F+0x03.
- Same-cycle pixel: pixel (51,2)=0xC0C0C0 (ring 3 -> 0x03 each) driven with frame_end -> result 0x030303, pixel_cnt 1.
- Saturation: ACC_W=12, 40 pixels (53,1)=0xFFFFFF -> acc clamps at 4095. OUT_SHIFT=0 -> result 0xFFFFFF; OUT_SHIFT=4 -> result 0xFFFFFF (255); OUT_SHIFT=5 -> result 0x7F7F7F; pixel_cnt 40.
- Restart: frame_start + frame_end in the same cycle after 2 ring-1 pixels 0x020202 -> result 0x020202, busy stays 1. The next frame with 1 ring-1 pixel 0x101010 -> result 0x080808, pixel_cnt 1.
